// File: rtl/tl_ctrl_pkg.sv
// rtl/tl_ctrl_pkg.sv - TileLink-UL control-bus field widths, beat structs and sizing helpers.
package tl_ctrl_pkg;

  localparam int OPCODE_W = 3;
  localparam int PARAM_W  = 3;
  localparam int SIZE_W   = 2;
  localparam int SOURCE_W = 7;
  localparam int ADDR_W   = 31;
  localparam int DATA_W   = 64;
  localparam int MASK_W   = 8;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [PARAM_W-1:0]  param;
    logic [SIZE_W-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic [ADDR_W-1:0]   address;
    logic [MASK_W-1:0]   mask;
    logic [DATA_W-1:0]   data;
    logic                corrupt;
  } tl_a_beat_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [SIZE_W-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic [DATA_W-1:0]   data;
  } tl_d_beat_t;

  // A one-entry queue still needs a 1-bit pointer to index its storage.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tl_ctrl_queue.sv
// rtl/tl_ctrl_queue.sv - registered ready/valid FIFO, no pipe or flow bypass.
module tl_ctrl_queue
  import tl_ctrl_pkg::*;
#(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clock,
  input  logic rst_n,
  input  logic enq_valid,
  output logic enq_ready,
  input  T     enq_data,
  output logic deq_valid,
  input  logic deq_ready,
  output T     deq_data
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             enq_fire;
  logic             deq_fire;

  // Handshake depends only on occupancy, so a full queue stays not-ready
  // even in a cycle where it is also being drained.
  assign enq_ready = (count < FULL);
  assign deq_valid = (count != '0);
  assign deq_data  = mem[rd_ptr];
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= next_ptr(wr_ptr);
      if (deq_fire) rd_ptr <= next_ptr(rd_ptr);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enq_fire) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/tl_ctrl_xing_buffer.sv
// rtl/tl_ctrl_xing_buffer.sv - registered TL-UL A/D buffer with outstanding-request limit.
module tl_ctrl_xing_buffer
  import tl_ctrl_pkg::*;
#(
  parameter int A_DEPTH      = 2,
  parameter int D_DEPTH      = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic                               auto_in_a_ready,
  input  logic                               auto_in_a_valid,
  input  logic [OPCODE_W-1:0]                auto_in_a_bits_opcode,
  input  logic [PARAM_W-1:0]                 auto_in_a_bits_param,
  input  logic [SIZE_W-1:0]                  auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0]                auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]                  auto_in_a_bits_address,
  input  logic [MASK_W-1:0]                  auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]                  auto_in_a_bits_data,
  input  logic                               auto_in_a_bits_corrupt,
  input  logic                               auto_in_d_ready,
  output logic                               auto_in_d_valid,
  output logic [OPCODE_W-1:0]                auto_in_d_bits_opcode,
  output logic [SIZE_W-1:0]                  auto_in_d_bits_size,
  output logic [SOURCE_W-1:0]                auto_in_d_bits_source,
  output logic [DATA_W-1:0]                  auto_in_d_bits_data,
  input  logic                               auto_out_a_ready,
  output logic                               auto_out_a_valid,
  output logic [OPCODE_W-1:0]                auto_out_a_bits_opcode,
  output logic [PARAM_W-1:0]                 auto_out_a_bits_param,
  output logic [SIZE_W-1:0]                  auto_out_a_bits_size,
  output logic [SOURCE_W-1:0]                auto_out_a_bits_source,
  output logic [ADDR_W-1:0]                  auto_out_a_bits_address,
  output logic [MASK_W-1:0]                  auto_out_a_bits_mask,
  output logic [DATA_W-1:0]                  auto_out_a_bits_data,
  output logic                               auto_out_a_bits_corrupt,
  output logic                               auto_out_d_ready,
  input  logic                               auto_out_d_valid,
  input  logic [OPCODE_W-1:0]                auto_out_d_bits_opcode,
  input  logic [SIZE_W-1:0]                  auto_out_d_bits_size,
  input  logic [SOURCE_W-1:0]                auto_out_d_bits_source,
  input  logic [DATA_W-1:0]                  auto_out_d_bits_data,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight
);

  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IF_W-1:0] IF_MAX = IF_W'(MAX_INFLIGHT);

  tl_a_beat_t a_in_beat;
  tl_a_beat_t a_head;
  tl_d_beat_t d_in_beat;
  tl_d_beat_t d_head;
  logic       a_enq_ready;
  logic       a_deq_valid;
  logic       d_enq_ready;
  logic       d_deq_valid;
  logic       issue_ok;
  logic       a_fire;
  logic       d_fire;

  assign a_in_beat = '{opcode:  auto_in_a_bits_opcode,
                       param:   auto_in_a_bits_param,
                       size:    auto_in_a_bits_size,
                       source:  auto_in_a_bits_source,
                       address: auto_in_a_bits_address,
                       mask:    auto_in_a_bits_mask,
                       data:    auto_in_a_bits_data,
                       corrupt: auto_in_a_bits_corrupt};

  assign d_in_beat = '{opcode: auto_out_d_bits_opcode,
                       size:   auto_out_d_bits_size,
                       source: auto_out_d_bits_source,
                       data:   auto_out_d_bits_data};

  // Every handshake output is masked by reset so nothing moves while it is held.
  assign issue_ok         = reset & (inflight < IF_MAX);
  assign auto_in_a_ready  = reset & a_enq_ready;
  assign auto_out_a_valid = a_deq_valid & issue_ok;
  assign auto_out_d_ready = reset & d_enq_ready;
  assign auto_in_d_valid  = reset & d_deq_valid;

  assign a_fire = auto_out_a_valid & auto_out_a_ready;
  assign d_fire = auto_in_d_valid & auto_in_d_ready;

  tl_ctrl_queue #(.T(tl_a_beat_t), .DEPTH(A_DEPTH)) u_a_queue (
    .clock     (clock),
    .rst_n     (reset),
    .enq_valid (auto_in_a_valid & reset),
    .enq_ready (a_enq_ready),
    .enq_data  (a_in_beat),
    .deq_valid (a_deq_valid),
    .deq_ready (auto_out_a_ready & issue_ok),
    .deq_data  (a_head)
  );

  tl_ctrl_queue #(.T(tl_d_beat_t), .DEPTH(D_DEPTH)) u_d_queue (
    .clock     (clock),
    .rst_n     (reset),
    .enq_valid (auto_out_d_valid & reset),
    .enq_ready (d_enq_ready),
    .enq_data  (d_in_beat),
    .deq_valid (d_deq_valid),
    .deq_ready (auto_in_d_ready),
    .deq_data  (d_head)
  );

  assign auto_out_a_bits_opcode  = a_head.opcode;
  assign auto_out_a_bits_param   = a_head.param;
  assign auto_out_a_bits_size    = a_head.size;
  assign auto_out_a_bits_source  = a_head.source;
  assign auto_out_a_bits_address = a_head.address;
  assign auto_out_a_bits_mask    = a_head.mask;
  assign auto_out_a_bits_data    = a_head.data;
  assign auto_out_a_bits_corrupt = a_head.corrupt;

  assign auto_in_d_bits_opcode = d_head.opcode;
  assign auto_in_d_bits_size   = d_head.size;
  assign auto_in_d_bits_source = d_head.source;
  assign auto_in_d_bits_data   = d_head.data;

  // A response delivered with nothing outstanding is dropped from the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else if (a_fire && !d_fire) begin
      inflight <= inflight + 1'b1;
    end else if (d_fire && !a_fire && inflight != '0) begin
      inflight <= inflight - 1'b1;
    end
  end

  d_without_request: assert property (@(posedge clock) disable iff (!reset)
    !(d_fire && inflight == '0));

endmodule

// File: tb/tb_tl_ctrl_xing_buffer.sv
// tb/tb_tl_ctrl_xing_buffer.sv - directed self-checking bench for tl_ctrl_xing_buffer.
module tb_tl_ctrl_xing_buffer;

  logic        clock;
  logic        reset;
  logic        in_a_ready;
  logic        in_a_valid;
  logic [2:0]  in_a_opcode;
  logic [2:0]  in_a_param;
  logic [1:0]  in_a_size;
  logic [6:0]  in_a_source;
  logic [30:0] in_a_address;
  logic [7:0]  in_a_mask;
  logic [63:0] in_a_data;
  logic        in_a_corrupt;
  logic        in_d_ready;
  logic        in_d_valid;
  logic [2:0]  in_d_opcode;
  logic [1:0]  in_d_size;
  logic [6:0]  in_d_source;
  logic [63:0] in_d_data;
  logic        out_a_ready;
  logic        out_a_valid;
  logic [2:0]  out_a_opcode;
  logic [2:0]  out_a_param;
  logic [1:0]  out_a_size;
  logic [6:0]  out_a_source;
  logic [30:0] out_a_address;
  logic [7:0]  out_a_mask;
  logic [63:0] out_a_data;
  logic        out_a_corrupt;
  logic        out_d_ready;
  logic        out_d_valid;
  logic [2:0]  out_d_opcode;
  logic [1:0]  out_d_size;
  logic [6:0]  out_d_source;
  logic [63:0] out_d_data;
  logic [2:0]  inflight;

  int vectors = 0;
  int miscompares = 0;

  tl_ctrl_xing_buffer #(.A_DEPTH(2), .D_DEPTH(2), .MAX_INFLIGHT(4)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .auto_in_a_ready         (in_a_ready),
    .auto_in_a_valid         (in_a_valid),
    .auto_in_a_bits_opcode   (in_a_opcode),
    .auto_in_a_bits_param    (in_a_param),
    .auto_in_a_bits_size     (in_a_size),
    .auto_in_a_bits_source   (in_a_source),
    .auto_in_a_bits_address  (in_a_address),
    .auto_in_a_bits_mask     (in_a_mask),
    .auto_in_a_bits_data     (in_a_data),
    .auto_in_a_bits_corrupt  (in_a_corrupt),
    .auto_in_d_ready         (in_d_ready),
    .auto_in_d_valid         (in_d_valid),
    .auto_in_d_bits_opcode   (in_d_opcode),
    .auto_in_d_bits_size     (in_d_size),
    .auto_in_d_bits_source   (in_d_source),
    .auto_in_d_bits_data     (in_d_data),
    .auto_out_a_ready        (out_a_ready),
    .auto_out_a_valid        (out_a_valid),
    .auto_out_a_bits_opcode  (out_a_opcode),
    .auto_out_a_bits_param   (out_a_param),
    .auto_out_a_bits_size    (out_a_size),
    .auto_out_a_bits_source  (out_a_source),
    .auto_out_a_bits_address (out_a_address),
    .auto_out_a_bits_mask    (out_a_mask),
    .auto_out_a_bits_data    (out_a_data),
    .auto_out_a_bits_corrupt (out_a_corrupt),
    .auto_out_d_ready        (out_d_ready),
    .auto_out_d_valid        (out_d_valid),
    .auto_out_d_bits_opcode  (out_d_opcode),
    .auto_out_d_bits_size    (out_d_size),
    .auto_out_d_bits_source  (out_d_source),
    .auto_out_d_bits_data    (out_d_data),
    .inflight                (inflight)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [6:0] src,
                         input logic [30:0] addr, input logic [63:0] data);
    in_a_opcode  = op;
    in_a_param   = 3'd0;
    in_a_size    = 2'd3;
    in_a_source  = src;
    in_a_address = addr;
    in_a_mask    = 8'hFF;
    in_a_data    = data;
    in_a_corrupt = 1'b0;
  endtask

  task automatic drive_d(input logic [6:0] src, input logic [63:0] data);
    out_d_opcode = 3'd1;
    out_d_size   = 2'd3;
    out_d_source = src;
    out_d_data   = data;
  endtask

  task automatic push_a(input logic [6:0] src);
    int n;
    n = 0;
    in_a_valid = 1'b1;
    drive_a(3'd0, src, 31'h0000_1000, 64'h5A00 + 64'(src));
    while (!in_a_ready && n < 20) begin
      step();
      n++;
    end
    chk("push_a_timeout", 64'(n < 20), 64'd1);
    step();
    in_a_valid = 1'b0;
  endtask

  initial begin
    int acc, iss, dcnt, dl, sent, got, n;
    logic a_in, a_out, d_out, d_in;
    logic [6:0] dev_q[$];

    reset = 1'b0;
    in_a_valid = 1'b0;
    drive_a(3'd0, 7'd0, 31'd0, 64'd0);
    in_d_ready = 1'b0;
    out_a_ready = 1'b0;
    out_d_valid = 1'b0;
    drive_d(7'd0, 64'd0);
    step();
    step();

    // reset state
    chk("rst_in_a_ready", 64'(in_a_ready), 64'd0);
    chk("rst_out_d_ready", 64'(out_d_ready), 64'd0);
    chk("rst_out_a_valid", 64'(out_a_valid), 64'd0);
    chk("rst_in_d_valid", 64'(in_d_valid), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_in_a_ready", 64'(in_a_ready), 64'd1);
    chk("post_rst_out_d_ready", 64'(out_d_ready), 64'd1);

    // single Get
    out_a_ready = 1'b1;
    in_a_valid = 1'b1;
    drive_a(3'd4, 7'h05, 31'h0200_0000, 64'd0);
    step();
    in_a_valid = 1'b0;
    chk("get_out_a_valid", 64'(out_a_valid), 64'd1);
    chk("get_opcode", 64'(out_a_opcode), 64'd4);
    chk("get_source", 64'(out_a_source), 64'h05);
    chk("get_address", 64'(out_a_address), 64'h0200_0000);
    chk("get_mask", 64'(out_a_mask), 64'hFF);
    chk("get_inflight_pre", 64'(inflight), 64'd0);
    step();
    chk("get_inflight", 64'(inflight), 64'd1);
    chk("get_out_a_drop", 64'(out_a_valid), 64'd0);
    out_d_valid = 1'b1;
    drive_d(7'h05, 64'hDEAD_BEEF_0000_0001);
    in_d_ready = 1'b1;
    step();
    out_d_valid = 1'b0;
    chk("get_in_d_valid", 64'(in_d_valid), 64'd1);
    chk("get_d_opcode", 64'(in_d_opcode), 64'd1);
    chk("get_d_source", 64'(in_d_source), 64'h05);
    chk("get_d_data", in_d_data, 64'hDEAD_BEEF_0000_0001);
    step();
    chk("get_inflight_done", 64'(inflight), 64'd0);
    chk("get_in_d_drop", 64'(in_d_valid), 64'd0);

    // inflight limit: 6 PutFull beats, no responses
    in_d_ready = 1'b0;
    acc = 0;
    iss = 0;
    for (int c = 0; c < 20; c++) begin
      in_a_valid = (acc < 6);
      drive_a(3'd0, 7'h10 + 7'(acc), 31'h0000_0100, 64'hA000 + 64'(acc));
      a_in = in_a_valid && in_a_ready;
      a_out = out_a_valid && out_a_ready;
      if (a_out) chk("lim_issue_src", 64'(out_a_source), 64'h10 + 64'(iss));
      step();
      if (a_in) acc++;
      if (a_out) iss++;
    end
    in_a_valid = 1'b0;
    chk("lim_issued", 64'(iss), 64'd4);
    chk("lim_accepted", 64'(acc), 64'd6);
    chk("lim_inflight", 64'(inflight), 64'd4);
    chk("lim_in_a_ready", 64'(in_a_ready), 64'd0);
    chk("lim_out_a_valid", 64'(out_a_valid), 64'd0);
    out_d_valid = 1'b1;
    drive_d(7'h10, 64'd0);
    step();
    out_d_valid = 1'b0;
    in_d_ready = 1'b1;
    chk("lim_d_valid", 64'(in_d_valid), 64'd1);
    step();
    chk("lim_inflight_3", 64'(inflight), 64'd3);
    chk("lim_fifth_valid", 64'(out_a_valid), 64'd1);
    chk("lim_fifth_src", 64'(out_a_source), 64'h14);
    step();
    chk("lim_inflight_4", 64'(inflight), 64'd4);
    chk("lim_sixth_held", 64'(out_a_valid), 64'd0);
    chk("lim_in_a_ready_1", 64'(in_a_ready), 64'd1);

    // simultaneous issue and response at inflight 2
    out_a_ready = 1'b0;
    out_d_valid = 1'b1;
    drive_d(7'h11, 64'd0);
    step();
    drive_d(7'h12, 64'd0);
    step();
    out_d_valid = 1'b0;
    step();
    chk("sim_inflight_2", 64'(inflight), 64'd2);
    chk("sim_a_pending", 64'(out_a_valid), 64'd1);
    in_d_ready = 1'b0;
    out_d_valid = 1'b1;
    drive_d(7'h13, 64'd0);
    step();
    out_d_valid = 1'b0;
    out_a_ready = 1'b1;
    in_d_ready = 1'b1;
    chk("sim_both_a", 64'(out_a_valid), 64'd1);
    chk("sim_both_d", 64'(in_d_valid), 64'd1);
    step();
    chk("sim_inflight_same", 64'(inflight), 64'd2);
    chk("sim_d_drained", 64'(in_d_valid), 64'd0);
    out_d_valid = 1'b1;
    drive_d(7'h14, 64'd0);
    step();
    drive_d(7'h15, 64'd0);
    step();
    out_d_valid = 1'b0;
    step();
    step();
    chk("sim_inflight_0", 64'(inflight), 64'd0);

    // D backpressure
    push_a(7'd1);
    push_a(7'd2);
    push_a(7'd3);
    step();
    step();
    chk("bp_inflight_3", 64'(inflight), 64'd3);
    in_d_ready = 1'b0;
    dcnt = 0;
    dl = 0;
    for (int c = 0; c < 6; c++) begin
      out_d_valid = (dcnt < 3);
      drive_d(7'(dcnt + 1), 64'h0D00 + 64'(dcnt + 1));
      d_out = out_d_valid && out_d_ready;
      step();
      if (d_out) dcnt++;
    end
    chk("bp_accepted", 64'(dcnt), 64'd2);
    chk("bp_out_d_ready", 64'(out_d_ready), 64'd0);
    in_d_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      out_d_valid = (dcnt < 3);
      drive_d(7'(dcnt + 1), 64'h0D00 + 64'(dcnt + 1));
      d_out = out_d_valid && out_d_ready;
      d_in = in_d_valid && in_d_ready;
      if (d_in) begin
        chk("bp_order_src", 64'(in_d_source), 64'(dl + 1));
        chk("bp_order_data", in_d_data, 64'h0D00 + 64'(dl + 1));
      end
      step();
      if (d_out) dcnt++;
      if (d_in) dl++;
    end
    out_d_valid = 1'b0;
    chk("bp_delivered", 64'(dl), 64'd3);
    chk("bp_inflight_0", 64'(inflight), 64'd0);

    // wrap-around stream with random stalls
    sent = 0;
    got = 0;
    iss = 0;
    n = 0;
    in_a_valid = 1'b0;
    while (got < 20 && n < 2000) begin
      if (!in_a_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
        in_a_valid = 1'b1;
        drive_a(3'd0, 7'(sent), 31'h100 + 31'(sent * 8), 64'hC0DE_0000_0000_0000 | 64'(sent));
      end
      out_a_ready = ($urandom_range(0, 3) != 0);
      in_d_ready = ($urandom_range(0, 3) != 0);
      out_d_valid = (dev_q.size() != 0) && ($urandom_range(0, 2) != 0);
      if (dev_q.size() != 0)
        drive_d(dev_q[0], (64'hC0DE_0000_0000_0000 | 64'(dev_q[0])) ^ 64'hFFFF_FFFF_0000_0000);
      a_in = in_a_valid && in_a_ready;
      a_out = out_a_valid && out_a_ready;
      d_out = out_d_valid && out_d_ready;
      d_in = in_d_valid && in_d_ready;
      if (a_out) begin
        chk("wrap_a_src", 64'(out_a_source), 64'(iss));
        chk("wrap_a_data", out_a_data, 64'hC0DE_0000_0000_0000 | 64'(iss));
        dev_q.push_back(out_a_source);
        iss++;
      end
      if (d_in) begin
        chk("wrap_d_src", 64'(in_d_source), 64'(got));
        chk("wrap_d_data", in_d_data,
            (64'hC0DE_0000_0000_0000 | 64'(got)) ^ 64'hFFFF_FFFF_0000_0000);
        got++;
      end
      step();
      n++;
      if (a_in) begin
        sent++;
        in_a_valid = 1'b0;
      end
      if (d_out) void'(dev_q.pop_front());
    end
    out_d_valid = 1'b0;
    chk("wrap_issued", 64'(iss), 64'd20);
    chk("wrap_delivered", 64'(got), 64'd20);
    chk("wrap_inflight_0", 64'(inflight), 64'd0);

    // reset mid-operation
    in_d_ready = 1'b0;
    out_a_ready = 1'b1;
    push_a(7'h40);
    step();
    out_a_ready = 1'b0;
    push_a(7'h41);
    push_a(7'h42);
    chk("mid_queued_full", 64'(in_a_ready), 64'd0);
    chk("mid_out_a_valid", 64'(out_a_valid), 64'd1);
    chk("mid_inflight_1", 64'(inflight), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_a_valid", 64'(out_a_valid), 64'd0);
    chk("mid_rst_in_a_ready", 64'(in_a_ready), 64'd0);
    chk("mid_rst_out_d_ready", 64'(out_d_ready), 64'd0);
    chk("mid_rst_inflight", 64'(inflight), 64'd0);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rel_in_a_ready", 64'(in_a_ready), 64'd1);
    chk("rel_out_a_empty", 64'(out_a_valid), 64'd0);
    chk("rel_in_d_empty", 64'(in_d_valid), 64'd0);
    chk("rel_inflight", 64'(inflight), 64'd0);
    out_a_ready = 1'b1;
    push_a(7'h50);
    chk("rel_new_valid", 64'(out_a_valid), 64'd1);
    chk("rel_new_src", 64'(out_a_source), 64'h50);
    step();
    chk("rel_new_inflight", 64'(inflight), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
